// File: rtl/mips_dmem_responder_if.sv
// Request/response channel between the MEM-stage initiator and the data-memory responder.
// Two independent valid/ready handshakes: one for requests, one for responses.
interface mips_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Handshaked word-addressed data memory with programmable wait states and range error.
// One transaction in flight: IDLE accepts, WAIT burns WAIT_CYCLES, RESP holds the result.
module mips_dmem_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic                  clkP,
  input logic                  rst,
  mips_dmem_responder_if.slave bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH];
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_accept;
  logic          w_access;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_accept = r_req_ready && bus.req_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so bypass the latches.
  assign w_access = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_we     = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_addr   = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
  assign w_err    = (w_addr >= 32'(DEPTH));
  assign w_idx    = w_addr[AW-1:0];

  always_ff @(posedge clkP) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= WAIT_LD;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // Stores commit only on the RESP entry edge, so a reset during WAIT drops them.
  always_ff @(posedge clkP) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_access && w_we && !w_err) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench: three responders (0, 3 and 4 wait states) behind one shared driver.
// Table vectors, directed corner sequences and random traffic against a word-array model.
module tb_mips_dmem_responder;
  logic clkP = 1'b0;
  logic rst;
  always #5 clkP = ~clkP;

  int cyc = 0;
  always @(posedge clkP) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int wait_of [3] = '{0, 3, 4};

  logic        tb_valid, tb_we, tb_rready;
  logic [31:0] tb_addr, tb_wdata;
  logic        m_rdy, m_rv, m_er;
  logic [31:0] m_rd;

  mips_dmem_responder_if b0 ();
  mips_dmem_responder_if b1 ();
  mips_dmem_responder_if b2 ();

  assign b0.req_valid = tb_valid && (sel == 0);
  assign b1.req_valid = tb_valid && (sel == 1);
  assign b2.req_valid = tb_valid && (sel == 2);
  assign b0.req_we = tb_we;  assign b0.req_addr = tb_addr;  assign b0.req_wdata = tb_wdata;
  assign b1.req_we = tb_we;  assign b1.req_addr = tb_addr;  assign b1.req_wdata = tb_wdata;
  assign b2.req_we = tb_we;  assign b2.req_addr = tb_addr;  assign b2.req_wdata = tb_wdata;
  assign b0.rsp_ready = tb_rready;
  assign b1.rsp_ready = tb_rready;
  assign b2.rsp_ready = tb_rready;

  mips_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_w0 (.clkP(clkP), .rst(rst), .bus(b0));
  mips_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(3)) u_w3 (.clkP(clkP), .rst(rst), .bus(b1));
  mips_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(4)) u_w4 (.clkP(clkP), .rst(rst), .bus(b2));

  always_comb begin
    m_rdy = b0.req_ready; m_rv = b0.rsp_valid; m_rd = b0.rsp_rdata; m_er = b0.rsp_err;
    case (sel)
      1: begin m_rdy = b1.req_ready; m_rv = b1.rsp_valid; m_rd = b1.rsp_rdata; m_er = b1.rsp_err; end
      2: begin m_rdy = b2.req_ready; m_rv = b2.rsp_valid; m_rd = b2.rsp_rdata; m_er = b2.rsp_err; end
      default: ;
    endcase
  end

  // Reference: plain word arrays, one per responder, updated by the memory rules.
  logic [31:0] ref_mem [3][16];

  task automatic ref_reset();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++) ref_mem[s][i] = '0;
  endtask

  task automatic model(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
    er = (a >= 32'd16);
    rd = '0;
    if (!er) begin
      if (we) ref_mem[s][a[3:0]] = d;
      else    rd = ref_mem[s][a[3:0]];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Entered and left just after a negedge; returns response fields, latency and accept cycle.
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input int hold,
                     input bit compete, output logic [31:0] rd, output logic er,
                     output int lat, output int acc);
    int n;
    bit bad;
    rd = '0; er = 1'b0; lat = 0; acc = 0; bad = 1'b0;
    tb_we = we; tb_addr = a; tb_wdata = d; tb_valid = 1'b1; tb_rready = (hold == 0);
    n = 0;
    while (!m_rdy && n < 50) begin @(negedge clkP); n++; end
    if (!m_rdy) begin
      chk("accept_timeout", 32'(m_rdy), 32'd1);
      tb_valid = 1'b0;
      return;
    end
    @(negedge clkP);
    acc = cyc;
    tb_valid = 1'b0;
    lat = 1;
    while (!m_rv && lat < 50) begin
      if (m_rdy) bad = 1'b1;
      @(negedge clkP);
      lat++;
    end
    chk("rsp_valid_seen", 32'(m_rv), 32'd1);
    rd = m_rd;
    er = m_er;
    if (m_rdy) bad = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (compete) begin tb_valid = 1'b1; tb_we = 1'b0; tb_addr = a ^ 32'h1; end
      @(negedge clkP);
      if (!m_rv || m_rd !== rd || m_er !== er || m_rdy) bad = 1'b1;
    end
    chk("busy_rdy_low_and_stable", 32'(bad), 32'd0);
    tb_rready = 1'b1;
    tb_valid  = 1'b0;
    @(negedge clkP);
    chk("post_handshake_idle", 32'({m_rv, m_rdy}), 32'h1);
  endtask

  task automatic run(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit compete, input string nm);
    logic [31:0] erd, rd;
    logic        eer, er;
    int          lat, acc;
    sel = s;
    model(s, we, a, d, erd, eer);
    txn(we, a, d, hold, compete, rd, er, lat, acc);
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_err"}, 32'(er), 32'(eer));
    chk({nm, "_latency"}, 32'(lat), 32'(wait_of[s] + 1));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat;
    int          acc [8];

    tbl[0] = '{1'b0, 32'd5,          32'h0,        32'h0,        1'b0};
    tbl[1] = '{1'b1, 32'd3,          32'hDEADBEEF, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 32'd3,          32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 32'd16,         32'h1234,     32'h0,        1'b1};
    tbl[4] = '{1'b0, 32'h80000000,   32'h0,        32'h0,        1'b1};
    tbl[5] = '{1'b1, 32'd15,         32'hCAFEF00D, 32'h0,        1'b0};
    tbl[6] = '{1'b0, 32'd15,         32'h0,        32'hCAFEF00D, 1'b0};
    tbl[7] = '{1'b0, 32'hFFFFFFFF,   32'h0,        32'h0,        1'b1};

    tb_valid = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0; tb_rready = 1'b0;
    rst = 1'b1;
    ref_reset();
    repeat (3) @(negedge clkP);
    rst = 1'b0;
    sel = 0;
    chk("reset_req_ready", 32'(m_rdy), 32'd1);
    chk("reset_rsp_valid", 32'(m_rv), 32'd0);
    chk("reset_rsp_rdata", m_rd, 32'd0);
    chk("reset_rsp_err", 32'(m_er), 32'd0);

    // Table vectors on the zero-wait responder
    for (int i = 0; i < 8; i++) begin
      model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, mrd, mer);
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 1'b0, rd, er, lat, acc[i]);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end
    chk("accept_spacing", 32'(acc[2] - acc[1]), 32'd2);

    // Out-of-range accesses must not have touched any word
    for (int i = 0; i < 16; i++) run(0, 1'b0, 32'(i), 32'h0, 0, 1'b0, $sformatf("readback%0d", i));

    // Backpressure with a competing request
    run(0, 1'b1, 32'd7, 32'hA5A5A5A5, 0, 1'b0, "bp_store");
    run(0, 1'b0, 32'd7, 32'h0, 5, 1'b1, "bp_load");
    @(negedge clkP);
    chk("bp_single_handshake", 32'({m_rv, m_rdy}), 32'h1);

    // Wait states then random traffic on the 3-wait responder
    run(1, 1'b0, 32'd0, 32'h0, 0, 1'b0, "wait3_load");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 4) == 0) ? $urandom() : 32'($urandom_range(0, 15));
      run(1, 1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
          $sformatf("rnd%0d", i));
    end

    // Reset two cycles after accepting a store on the 4-wait responder
    sel = 2;
    tb_we = 1'b1; tb_addr = 32'd2; tb_wdata = 32'h55; tb_valid = 1'b1; tb_rready = 1'b1;
    chk("midwait_pre_ready", 32'(m_rdy), 32'd1);
    @(negedge clkP);
    tb_valid = 1'b0;
    @(negedge clkP);
    rst = 1'b1;
    @(negedge clkP);
    rst = 1'b0;
    ref_reset();
    chk("midwait_rst_req_ready", 32'(m_rdy), 32'd1);
    chk("midwait_rst_rsp_valid", 32'(m_rv), 32'd0);
    chk("midwait_rst_rsp_rdata", m_rd, 32'd0);
    chk("midwait_rst_rsp_err", 32'(m_er), 32'd0);
    run(2, 1'b0, 32'd2, 32'h0, 0, 1'b0, "midwait_load");
    run(0, 1'b0, 32'd7, 32'h0, 0, 1'b0, "rst_clears_w0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
